// File: rtl/ttpu_pkg.sv
// Shared types and constants for the post-MAC datapath blocks.
package ttpu_pkg;

    // Sequencer states; encoding is also exported on the debug port.
    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        FETCH    = 4'd1,
        LOAD     = 4'd2,
        START    = 4'd3,
        WAIT_RDY = 4'd4,
        WRITE    = 4'd5,
        RELEASE  = 4'd6,
        DONE     = 4'd7,
        ERR      = 4'd8
    } vas_state_t;

    // FP16 bit patterns used when building stimulus.
    localparam logic [15:0] FP16_ZERO  = 16'h0000;
    localparam logic [15:0] FP16_ONE   = 16'h3C00;
    localparam logic [15:0] FP16_TWO   = 16'h4000;
    localparam logic [15:0] FP16_THREE = 16'h4200;

endpackage

// File: rtl/vector_add_sequencer.sv
// Vector-adder initiator: accepts a bias-add job, streams source rows through
// the adder one at a time and writes each masked result to the destination.
//
// Handshakes:
//  - Command: a job is accepted on a cycle with cmd_valid=1 and cmd_ready=1;
//    cmd_ready is high only in IDLE, so commands offered while busy are ignored.
//  - Adder: va_start is a held level; a result is taken only when va_ready=1
//    is seen in WAIT_RDY. After the write, va_start drops and the sequencer
//    waits for va_ready=0 before starting the next row, so a stale ready is
//    never mistaken for a new result and va_start never rises while ready=1.
module vector_add_sequencer
    import ttpu_pkg::*;
#(
    parameter int DATA_WIDTH     = 16,
    parameter int NUM_UNITS      = 16,
    parameter int ADDR_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            cmd_valid,
    output logic                            cmd_ready,
    input  logic [ADDR_WIDTH-1:0]           cmd_src_base,
    input  logic [ADDR_WIDTH-1:0]           cmd_dst_base,
    input  logic [ADDR_WIDTH:0]             cmd_rows,
    input  logic [NUM_UNITS-1:0]            cmd_mask,
    input  logic [NUM_UNITS*DATA_WIDTH-1:0] cmd_bias,
    output logic                            src_rd_en,
    output logic [ADDR_WIDTH-1:0]           src_rd_addr,
    input  logic [NUM_UNITS*DATA_WIDTH-1:0] src_rd_data,
    output logic                            va_start,
    output logic [NUM_UNITS-1:0]            va_active,
    output logic [NUM_UNITS*DATA_WIDTH-1:0] va_in_x,
    output logic [NUM_UNITS*DATA_WIDTH-1:0] va_in_bias,
    input  logic [NUM_UNITS*DATA_WIDTH-1:0] va_out,
    input  logic                            va_ready,
    output logic                            dst_wr_en,
    output logic [ADDR_WIDTH-1:0]           dst_wr_addr,
    output logic [NUM_UNITS*DATA_WIDTH-1:0] dst_wr_data,
    output logic [NUM_UNITS-1:0]            dst_wr_mask,
    output logic                            busy,
    output logic                            done,
    output logic                            timeout_err,
    output logic [3:0]                      state_dbg
);

    localparam int ROW_W = NUM_UNITS * DATA_WIDTH;
    localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYCLES);

    vas_state_t state, next_state;

    logic [ADDR_WIDTH-1:0] src_ptr, dst_ptr;
    logic [ADDR_WIDTH:0]   rows_left;
    logic [NUM_UNITS-1:0]  mask_q;
    logic [ROW_W-1:0]      bias_q, x_q, wr_q, va_out_masked;
    logic                  err_q;
    logic [WD_W-1:0]       wd_cnt;
    logic                  accept, wd_expired;

    assign accept     = cmd_valid && (state == IDLE);
    assign wd_expired = (wd_cnt == WD_LIMIT);

    // State register; reset abandons any job in flight.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // Next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:     if (accept) next_state = (cmd_rows == '0) ? DONE : FETCH;
            FETCH:    next_state = LOAD;
            LOAD:     next_state = START;
            START:    next_state = WAIT_RDY;
            WAIT_RDY: begin
                if (va_ready)        next_state = WRITE;
                else if (wd_expired) next_state = ERR;
            end
            WRITE:    next_state = RELEASE;
            RELEASE:  begin
                if (!va_ready)       next_state = (rows_left == '0) ? DONE : FETCH;
                else if (wd_expired) next_state = ERR;
            end
            DONE:     next_state = IDLE;
            ERR:      next_state = DONE;
            default:  next_state = IDLE;
        endcase
    end

    // State-decoded strobes.
    always_comb begin
        cmd_ready = (state == IDLE);
        busy      = (state != IDLE);
        src_rd_en = (state == FETCH);
        va_start  = (state == START) || (state == WAIT_RDY);
        dst_wr_en = (state == WRITE);
        done      = (state == DONE);
    end

    // Zero the result lanes the job does not own.
    always_comb begin
        va_out_masked = '0;
        for (int i = 0; i < NUM_UNITS; i++) begin
            if (mask_q[i]) va_out_masked[i*DATA_WIDTH +: DATA_WIDTH] = va_out[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Job registers: latched on accept, advanced as rows move through the adder.
    always_ff @(posedge clk) begin
        if (reset) begin
            src_ptr   <= '0;
            dst_ptr   <= '0;
            rows_left <= '0;
            mask_q    <= '0;
            bias_q    <= '0;
            x_q       <= '0;
            wr_q      <= '0;
            err_q     <= 1'b0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    src_ptr   <= cmd_src_base;
                    dst_ptr   <= cmd_dst_base;
                    rows_left <= cmd_rows;
                    mask_q    <= cmd_mask;
                    bias_q    <= cmd_bias;
                    err_q     <= 1'b0;
                end
                LOAD: begin
                    x_q     <= src_rd_data;
                    src_ptr <= src_ptr + ADDR_WIDTH'(1);
                end
                WAIT_RDY: if (va_ready) wr_q <= va_out_masked;
                WRITE: begin
                    dst_ptr   <= dst_ptr + ADDR_WIDTH'(1);
                    rows_left <= rows_left - (ADDR_WIDTH+1)'(1);
                end
                ERR: err_q <= 1'b1;
                default: ;
            endcase
        end
    end

    // Watchdog: restarts on every state change, counts only while waiting on va_ready.
    always_ff @(posedge clk) begin
        if (reset || (next_state != state)) begin
            wd_cnt <= '0;
        end else if (((state == WAIT_RDY) || (state == RELEASE)) && !wd_expired) begin
            wd_cnt <= wd_cnt + WD_W'(1);
        end
    end

    assign src_rd_addr = src_ptr;
    assign va_active   = mask_q;
    assign va_in_x     = x_q;
    assign va_in_bias  = bias_q;
    assign dst_wr_addr = dst_ptr;
    assign dst_wr_data = wr_q;
    assign dst_wr_mask = mask_q;
    assign timeout_err = err_q;
    assign state_dbg   = state;

endmodule
